// File: rtl/while_loop_sched.sv
// -----------------------------------------------------------------------------
// while_loop_sched
//
// Multi-cycle sequencer for the bounded while-loop datapath
//     XOUT = temp*A - B,  temp starting at 1 and incremented COUNT times.
// One loop iteration is executed per clock, followed by a single
// multiply/subtract cycle. The request side and the result side are both
// valid/ready handshakes; requests never overlap.
//
// Ports
//   CLK        clock, all state changes on the rising edge
//   RST        asynchronous, active-high reset
//   IN_VALID   request present on A/B/COUNT
//   IN_READY   block can accept a request (high only in IDLE)
//   A          multiplicand, unsigned, NBITS wide
//   B          subtrahend, unsigned, NBITS wide
//   COUNT      number of loop iterations, unsigned, CNTBITS wide, 0 allowed
//   OUT_VALID  XOUT holds a completed result
//   OUT_READY  sink accepts the result
//   XOUT       result modulo 2^NBITS
//   BUSY       high whenever the sequencer is not IDLE
//   NDONE      count of results handed off, wraps at 2^NBITS
// -----------------------------------------------------------------------------
module while_loop_sched #(
  parameter int NBITS   = 8,
  parameter int CNTBITS = 4
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               IN_VALID,
  output logic               IN_READY,
  input  logic [NBITS-1:0]   A,
  input  logic [NBITS-1:0]   B,
  input  logic [CNTBITS-1:0] COUNT,
  output logic               OUT_VALID,
  input  logic               OUT_READY,
  output logic [NBITS-1:0]   XOUT,
  output logic               BUSY,
  output logic [NBITS-1:0]   NDONE
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOOP = 2'd1,
    MULT = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [NBITS-1:0]   ONE_N   = NBITS'(1);
  localparam logic [CNTBITS-1:0] ONE_C   = CNTBITS'(1);
  localparam logic [CNTBITS-1:0] ZERO_C  = '0;
  localparam logic [NBITS-1:0]   ZERO_N  = '0;
  localparam logic [NBITS-1:0]   PAD_N   = '0;

  state_t               state_r;
  state_t               state_next;
  logic [NBITS-1:0]     a_r;
  logic [NBITS-1:0]     a_next;
  logic [NBITS-1:0]     b_r;
  logic [NBITS-1:0]     b_next;
  logic [NBITS-1:0]     temp_r;
  logic [NBITS-1:0]     temp_next;
  logic [CNTBITS-1:0]   rem_r;
  logic [CNTBITS-1:0]   rem_next;
  logic [NBITS-1:0]     xout_r;
  logic [NBITS-1:0]     xout_next;
  logic [NBITS-1:0]     ndone_r;
  logic [NBITS-1:0]     ndone_next;
  logic                 in_ready_r;
  logic                 out_valid_r;
  logic                 busy_r;
  logic [2*NBITS-1:0]   product;

  // Full-width product; only the low NBITS bits feed the subtract.
  assign product = {PAD_N, temp_r} * {PAD_N, a_r};

  // Next-state and datapath-next logic; every register holds by default.
  always_comb begin
    state_next = state_r;
    a_next     = a_r;
    b_next     = b_r;
    temp_next  = temp_r;
    rem_next   = rem_r;
    xout_next  = xout_r;
    ndone_next = ndone_r;
    case (state_r)
      IDLE: begin
        if (IN_VALID) begin
          a_next    = A;
          b_next    = B;
          rem_next  = COUNT;
          temp_next = ONE_N;
          if (COUNT != ZERO_C) begin
            state_next = LOOP;
          end else begin
            state_next = MULT;
          end
        end else begin
          state_next = IDLE;
        end
      end
      LOOP: begin
        temp_next = temp_r + ONE_N;
        rem_next  = rem_r - ONE_C;
        // rem never reaches 0 inside LOOP; <= guards an unreachable wrap.
        if (rem_r <= ONE_C) begin
          state_next = MULT;
        end else begin
          state_next = LOOP;
        end
      end
      MULT: begin
        xout_next  = product[NBITS-1:0] - b_r;
        state_next = DONE;
      end
      DONE: begin
        if (OUT_READY) begin
          ndone_next = ndone_r + ONE_N;
          state_next = IDLE;
        end else begin
          state_next = DONE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next;
    end
  end

  // Operand, loop and result registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      a_r     <= ZERO_N;
      b_r     <= ZERO_N;
      temp_r  <= ONE_N;
      rem_r   <= ZERO_C;
      xout_r  <= ZERO_N;
      ndone_r <= ZERO_N;
    end else begin
      a_r     <= a_next;
      b_r     <= b_next;
      temp_r  <= temp_next;
      rem_r   <= rem_next;
      xout_r  <= xout_next;
      ndone_r <= ndone_next;
    end
  end

  // Handshake/status flags registered from the next state so they track
  // the state register exactly without any combinational input path.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      in_ready_r  <= (state_next == IDLE);
      out_valid_r <= (state_next == DONE);
      busy_r      <= (state_next != IDLE);
    end
  end

  assign IN_READY  = in_ready_r;
  assign OUT_VALID = out_valid_r;
  assign BUSY      = busy_r;
  assign XOUT      = xout_r;
  assign NDONE     = ndone_r;

endmodule

// File: tb/tb_while_loop_sched.sv
// -----------------------------------------------------------------------------
// tb_while_loop_sched
//
// Directed bench for while_loop_sched. A transaction-level model (countdown
// to result, closed-form result (COUNT+1)*A-B mod 256) is compared with the
// DUT outputs on every falling edge; directed scenarios add literal checks.
// -----------------------------------------------------------------------------
module tb_while_loop_sched;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       IN_VALID;
  logic       IN_READY;
  logic [7:0] A;
  logic [7:0] B;
  logic [3:0] COUNT;
  logic       OUT_VALID;
  logic       OUT_READY;
  logic [7:0] XOUT;
  logic       BUSY;
  logic [7:0] NDONE;

  while_loop_sched #(.NBITS(8), .CNTBITS(4)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .A         (A),
    .B         (B),
    .COUNT     (COUNT),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .XOUT      (XOUT),
    .BUSY      (BUSY),
    .NDONE     (NDONE)
  );

  initial begin
    forever #5 CLK = ~CLK;
  end

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int t0      = 0;
  bit chk_en  = 1'b0;

  // Transaction model state
  bit       m_busy    = 1'b0;
  bit       m_valid   = 1'b0;
  int       m_left    = 0;
  logic [7:0] m_pending = 8'd0;
  logic [7:0] m_xout    = 8'd0;
  logic [7:0] m_ndone   = 8'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Rising-edge counter used to measure latencies.
  always @(posedge CLK) cyc <= cyc + 1;

  // Model: accept when idle, result appears COUNT+1 edges later,
  // held until the sink takes it.
  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      m_busy    <= 1'b0;
      m_valid   <= 1'b0;
      m_left    <= 0;
      m_pending <= 8'd0;
      m_xout    <= 8'd0;
      m_ndone   <= 8'd0;
    end else if (!m_busy) begin
      if (IN_VALID === 1'b1) begin
        m_busy    <= 1'b1;
        m_left    <= int'(COUNT) + 1;
        m_pending <= 8'((int'(COUNT) + 1) * int'(A) - int'(B));
      end
    end else if (!m_valid) begin
      if (m_left == 1) begin
        m_valid <= 1'b1;
        m_xout  <= m_pending;
      end
      m_left <= m_left - 1;
    end else if (OUT_READY === 1'b1) begin
      m_valid <= 1'b0;
      m_busy  <= 1'b0;
      m_ndone <= m_ndone + 8'd1;
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge CLK) begin
    if (chk_en) begin
      check("in_ready",  IN_READY,  !m_busy);
      check("busy",      BUSY,      m_busy);
      check("out_valid", OUT_VALID, m_valid);
      check("xout",      XOUT,      m_xout);
      check("ndone",     NDONE,     m_ndone);
    end
  end

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [3:0] c);
    int n;
    n = 0;
    while (!IN_READY && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 50) check("send_timeout", 32'd1, 32'd0);
    IN_VALID = 1'b1;
    A        = a;
    B        = b;
    COUNT    = c;
    @(negedge CLK);
    IN_VALID = 1'b0;
    t0       = cyc;
  endtask

  task automatic wait_valid(output int lat);
    int n;
    n = 0;
    while (!OUT_VALID && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 50) check("valid_timeout", 32'd1, 32'd0);
    lat = cyc - t0;
  endtask

  initial begin
    int lat;
    int n_acc;
    int prev;
    int guard;
    IN_VALID  = 1'b0;
    A         = 8'd0;
    B         = 8'd0;
    COUNT     = 4'd0;
    OUT_READY = 1'b1;
    #1 RST = 1'b1;
    #2;
    check("rst_in_ready",  IN_READY,  1);
    check("rst_out_valid", OUT_VALID, 0);
    check("rst_busy",      BUSY,      0);
    check("rst_xout",      XOUT,      0);
    check("rst_ndone",     NDONE,     0);
    @(negedge CLK);
    RST    = 1'b0;
    chk_en = 1'b1;
    @(negedge CLK);

    // Basic run: 5*3-2
    send(8'd3, 8'd2, 4'd4);
    wait_valid(lat);
    check("basic_lat",  lat,  5);
    check("basic_xout", XOUT, 13);
    @(negedge CLK);
    check("basic_ndone",    NDONE,    1);
    check("basic_in_ready", IN_READY, 1);

    // Zero iterations with underflow: 7-9 mod 256
    send(8'd7, 8'd9, 4'd0);
    wait_valid(lat);
    check("zero_lat",  lat,  1);
    check("zero_xout", XOUT, 254);
    @(negedge CLK);

    // Product truncation: 4*200 mod 256
    send(8'd200, 8'd0, 4'd3);
    wait_valid(lat);
    check("trunc_lat",  lat,  4);
    check("trunc_xout", XOUT, 32);
    @(negedge CLK);

    // Backpressure and input isolation: 3*5-1
    OUT_READY = 1'b0;
    send(8'd5, 8'd1, 4'd2);
    A     = 8'd99;
    B     = 8'd77;
    COUNT = 4'd9;
    wait_valid(lat);
    check("bp_lat", lat, 3);
    for (int i = 0; i < 4; i++) begin
      IN_VALID = i[0];
      @(negedge CLK);
      check("bp_xout",      XOUT,      14);
      check("bp_out_valid", OUT_VALID, 1);
      check("bp_in_ready",  IN_READY,  0);
    end
    IN_VALID  = 1'b0;
    OUT_READY = 1'b1;
    @(negedge CLK);
    check("bp_release_valid", OUT_VALID, 0);
    check("bp_ndone",         NDONE,     4);

    // Asynchronous reset during the third LOOP cycle
    send(8'd4, 8'd0, 4'd10);
    @(negedge CLK);
    @(negedge CLK);
    #2 RST = 1'b1;
    #1;
    check("mid_rst_in_ready",  IN_READY,  1);
    check("mid_rst_out_valid", OUT_VALID, 0);
    check("mid_rst_busy",      BUSY,      0);
    check("mid_rst_xout",      XOUT,      0);
    check("mid_rst_ndone",     NDONE,     0);
    #1 RST = 1'b0;
    @(negedge CLK);
    send(8'd2, 8'd1, 4'd1);
    wait_valid(lat);
    check("post_rst_lat",  lat,  2);
    check("post_rst_xout", XOUT, 3);
    @(negedge CLK);
    check("post_rst_ndone", NDONE, 1);

    // Fresh start, then 257 back-to-back requests
    #2 RST = 1'b1;
    #2 RST = 1'b0;
    @(negedge CLK);
    A         = 8'd1;
    B         = 8'd0;
    COUNT     = 4'd0;
    OUT_READY = 1'b1;
    IN_VALID  = 1'b1;
    n_acc     = 0;
    prev      = 0;
    guard     = 0;
    while (n_acc < 257 && guard < 3000) begin
      if (OUT_VALID) check("b2b_xout", XOUT, 1);
      if (IN_READY) begin
        if (n_acc > 0) check("b2b_interval", cyc - prev, 3);
        prev = cyc;
        n_acc++;
      end
      @(negedge CLK);
      guard++;
      if (n_acc == 257) IN_VALID = 1'b0;
    end
    IN_VALID = 1'b0;
    check("b2b_count", n_acc, 257);
    guard = 0;
    while (BUSY && guard < 20) begin
      @(negedge CLK);
      guard++;
    end
    check("b2b_idle",  BUSY,  0);
    check("b2b_ndone", NDONE, 1);
    @(negedge CLK);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
